// File: rtl/smc_bound_ctrl_if.sv
// Command/bound bundle between the CPU execute stage, smc_bound_ctrl and the SMC range checker.
interface smc_bound_ctrl_if #(
    parameter int unsigned AW = 32
);
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_data;
    logic          cmd_ready;
    logic [AW-1:0] low_bound;
    logic [AW-1:0] high_bound;
    logic          smc_ce;
    logic          err;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, low_bound, high_bound, smc_ce, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, low_bound, high_bound, smc_ce, err
    );
endinterface

// File: rtl/smc_bound_ctrl.sv
// SMC bound programming front end: loads, validates and arms the low/high bound registers.
// Optional cache-line alignment of stored bounds is enabled by defining SMC_BOUND_ALIGN_EN.
module smc_bound_ctrl #(
    parameter int unsigned AW        = 32,
    parameter int unsigned LINE_BITS = 4
) (
    input logic           clk,
    input logic           rst,
    smc_bound_ctrl_if.slave bus
);
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOW   = 2'b01;
    localparam logic [1:0] OP_HIGH  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

`ifdef SMC_BOUND_ALIGN_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // Low bound clears these bits, high bound sets them; all-zero when alignment is off.
    localparam logic [AW-1:0] LINE_MASK =
        ALIGN_EN ? AW'((64'd1 << LINE_BITS) - 64'd1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALF,
        S_CHECK,
        S_ARMED,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] low_q, low_d;
    logic [AW-1:0] high_q, high_d;
    logic          ready_q, ce_q, err_q;
    logic          accept;

    assign accept = bus.cmd_valid & ready_q;

    // Next-state and bound-update logic.
    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        high_d  = high_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.cmd_op == OP_LOW) begin
                        low_d   = bus.cmd_data & ~LINE_MASK;
                        state_d = S_HALF;
                    end else if (bus.cmd_op == OP_HIGH) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_HALF: begin
                if (accept) begin
                    if (bus.cmd_op == OP_LOW) begin
                        low_d = bus.cmd_data & ~LINE_MASK;
                    end else if (bus.cmd_op == OP_HIGH) begin
                        high_d  = bus.cmd_data | LINE_MASK;
                        state_d = S_CHECK;
                    end else if (bus.cmd_op == OP_CLEAR) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHECK: begin
                state_d = (high_q >= low_q) ? S_ARMED : S_ERR;
            end
            S_ARMED: begin
                if (accept) begin
                    if (bus.cmd_op == OP_LOW || bus.cmd_op == OP_HIGH) begin
                        state_d = S_ERR;
                    end else if (bus.cmd_op == OP_CLEAR) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ERR: begin
                if (accept && bus.cmd_op == OP_CLEAR) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // CLEAR wipes both bounds; it is never accepted during CHECK.
        if (accept && bus.cmd_op == OP_CLEAR) begin
            low_d  = '0;
            high_d = '0;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            low_q   <= '0;
            high_q  <= '0;
            ready_q <= 1'b1;
            ce_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
            ready_q <= (state_d != S_CHECK);
            ce_q    <= (state_d == S_ARMED);
            err_q   <= (state_d == S_ERR);
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.low_bound  = low_q;
    assign bus.high_bound = high_q;
    assign bus.smc_ce     = ce_q;
    assign bus.err        = err_q;

    logic unused_nop;
    assign unused_nop = (OP_NOP == 2'b00);
endmodule

// File: tb/tb_smc_bound_ctrl.sv
// Self-checking bench for smc_bound_ctrl: directed vector table, async-reset sequence, random vs model.
module tb_smc_bound_ctrl;
    localparam int unsigned AW = 32;
    localparam logic [1:0] NOP = 2'b00, LOW = 2'b01, HIGH = 2'b10, CLR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    smc_bound_ctrl_if #(.AW(AW)) bus ();

    smc_bound_ctrl #(.AW(AW), .LINE_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] al_lo(input logic [31:0] d);
`ifdef SMC_BOUND_ALIGN_EN
        return {d[31:4], 4'h0};
`else
        return d;
`endif
    endfunction

    function automatic logic [31:0] al_hi(input logic [31:0] d);
`ifdef SMC_BOUND_ALIGN_EN
        return {d[31:4], 4'hF};
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                           input bit ce, input bit er, input bit rdy);
        chk({tag, ".low"},   bus.low_bound, lo);
        chk({tag, ".high"},  bus.high_bound, hi);
        chk({tag, ".ce"},    32'(bus.smc_ce), 32'(ce));
        chk({tag, ".err"},   32'(bus.err), 32'(er));
        chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'(rdy));
    endtask

    // Apply one command at the falling edge, then sample just after the next rising edge.
    task automatic cycle(input bit v, input logic [1:0] op, input logic [31:0] d);
        @(negedge clk);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Reference model: compartment described by what has been loaded and whether it is live.
    logic [31:0] m_lo, m_hi;
    bit m_have_low, m_checking, m_armed, m_err;

    task automatic model_reset();
        m_lo = '0; m_hi = '0;
        m_have_low = 0; m_checking = 0; m_armed = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [1:0] op, input logic [31:0] d);
        if (m_checking) begin
            m_checking = 0;
            if (m_hi >= m_lo) m_armed = 1;
            else m_err = 1;
        end else if (v) begin
            if (op == CLR) begin
                model_reset();
            end else if (op != NOP && !m_err) begin
                if (m_armed) begin
                    m_armed = 0;
                    m_err   = 1;
                end else if (op == LOW) begin
                    m_lo = al_lo(d);
                    m_have_low = 1;
                end else if (!m_have_low) begin
                    m_err = 1;
                end else begin
                    m_hi = al_hi(d);
                    m_have_low = 0;
                    m_checking = 1;
                end
            end
        end
    endtask

    typedef struct {
        bit          v;
        logic [1:0]  op;
        logic [31:0] d;
        logic [31:0] lo, hi;
        bit          ce, er, rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit v, input logic [1:0] op, input logic [31:0] d,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input bit ce, input bit er, input bit rdy);
        vec_t t;
        t.v = v; t.op = op; t.d = d; t.lo = lo; t.hi = hi;
        t.ce = ce; t.er = er; t.rdy = rdy;
        vecs.push_back(t);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = NOP;
        bus.cmd_data  = '0;

        // Bound values chosen so aligned and unaligned builds expect the same results.
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, LOW,  32'h1000,      32'h1000,      32'h0,     0, 0, 1);
        add(1, HIGH, 32'h1FFF,      32'h1000,      32'h1FFF,  0, 0, 0);
        add(0, NOP,  32'h0,         32'h1000,      32'h1FFF,  1, 0, 1);
        add(1, NOP,  32'hDEAD,      32'h1000,      32'h1FFF,  1, 0, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, LOW,  32'h2000,      32'h2000,      32'h0,     0, 0, 1);
        add(1, HIGH, 32'h0FFF,      32'h2000,      32'h0FFF,  0, 0, 0);
        add(0, NOP,  32'h0,         32'h2000,      32'h0FFF,  0, 1, 1);
        add(1, LOW,  32'h3000,      32'h2000,      32'h0FFF,  0, 1, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, LOW,  32'h1000,      32'h1000,      32'h0,     0, 0, 1);
        add(1, HIGH, 32'h1FFF,      32'h1000,      32'h1FFF,  0, 0, 0);
        add(0, NOP,  32'h0,         32'h1000,      32'h1FFF,  1, 0, 1);
        add(1, LOW,  32'h3000,      32'h1000,      32'h1FFF,  0, 1, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, HIGH, 32'h5FFF,      32'h0,         32'h0,     0, 1, 1);
        add(1, LOW,  32'h6000,      32'h0,         32'h0,     0, 1, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, LOW,  32'h7000,      32'h7000,      32'h0,     0, 0, 1);
        add(1, LOW,  32'h8000,      32'h8000,      32'h0,     0, 0, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, LOW,  32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0,     0, 0, 1);
        add(1, HIGH, 32'h0000_001F, 32'hFFFF_FFF0, 32'h1F,    0, 0, 0);
        add(0, NOP,  32'h0,         32'hFFFF_FFF0, 32'h1F,    0, 1, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);
        add(1, LOW,  32'h0100,      32'h0100,      32'h0,     0, 0, 1);
        add(1, HIGH, 32'h01FF,      32'h0100,      32'h01FF,  0, 0, 0);
        add(1, CLR,  32'h0,         32'h0100,      32'h01FF,  1, 0, 1);
        add(1, HIGH, 32'h0900,      32'h0100,      32'h01FF,  0, 1, 1);
        add(1, CLR,  32'h0,         32'h0,         32'h0,     0, 0, 1);

        #12;
        chk_all("reset", 32'h0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            cycle(vecs[i].v, vecs[i].op, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi,
                    vecs[i].ce, vecs[i].er, vecs[i].rdy);
        end

        // Armed, then reset asserted between edges must clear outputs without a clock.
        cycle(1, LOW, 32'h1000);
        cycle(1, HIGH, 32'h1FFF);
        cycle(0, NOP, 32'h0);
        chk("pre_rst.ce", 32'(bus.smc_ce), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'h0, 32'h0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;

        // Single-address compartment.
        cycle(1, LOW, 32'h4000);
        cycle(1, HIGH, 32'h4000);
        chk("eq.ready_check", 32'(bus.cmd_ready), 32'd0);
        cycle(0, NOP, 32'h0);
        chk_all("eq.armed", al_lo(32'h4000), al_hi(32'h4000), 1, 0, 1);

`ifdef SMC_BOUND_ALIGN_EN
        cycle(1, CLR, 32'h0);
        cycle(1, LOW, 32'h1234);
        cycle(1, HIGH, 32'h1236);
        cycle(0, NOP, 32'h0);
        chk_all("align", 32'h1230, 32'h123F, 1, 0, 1);
`endif

        // Random traffic against the model; mostly small values so both orders occur.
        cycle(1, CLR, 32'h0);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            bit          v;
            logic [1:0]  op;
            logic [31:0] d;
            v  = ($urandom_range(0, 9) != 0);
            op = 2'($urandom_range(0, 3));
            d  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
            cycle(v, op, d);
            model_step(v, op, d);
            chk_all($sformatf("rnd%0d", n), m_lo, m_hi, m_armed, m_err, !m_checking);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
